// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS control FSM and its datapath.
// master: the control FSM (drives all datapath controls, reads opcode/mem_ready).
// slave : the datapath/memory side (drives opcode/mem_ready, reads controls).
// Signals:
//   opcode[5:0]    instruction[31:26] held in IR
//   mem_ready      memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0]  datapath mux selects / enables
//   illegal_op, mem_fault  one-cycle event pulses
//   retired[CNT_W-1:0]     completed-instruction count
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic             mem_fault;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_fault, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_fault, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core. Sequences fetch, decode,
// execute, memory and writeback and drives all datapath controls through the
// bus interface (master side). Memory states wait on mem_ready and abort to
// FETCH with a mem_fault pulse after TIMEOUT_CYCLES cycles without it.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mips_multicycle_ctrl_if.master (opcode/mem_ready in, controls out)
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EX     = 4'd7,
    R_WB     = 4'd8,
    I_EX     = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_ADDI  = 6'b001000;
  localparam logic [5:0]  OP_ANDI  = 6'b001100;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic [15:0]      tmo_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             waiting, timed_out, retire;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_fault;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // mem_ready in the final allowed cycle takes priority over the timeout.
  assign waiting   = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR))
                     && !bus.mem_ready;
  assign timed_out = waiting && (tmo_cnt == TMO_LAST);

  always_comb begin
    next_state    = state;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    mem_fault     = 1'b0;
    unique case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) next_state = DECODE;
        else if (timed_out) mem_fault = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:       next_state = R_EX;
          OP_LW, OP_SW:   next_state = MEM_ADDR;
          OP_BEQ:         next_state = BRANCH;
          OP_J:           next_state = JUMP;
          OP_ADDI, OP_ANDI: next_state = I_EX;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) next_state = MEM_WB;
        else if (timed_out) begin
          mem_fault  = 1'b1;
          next_state = FETCH;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end else if (timed_out) begin
          mem_fault  = 1'b1;
          next_state = FETCH;
        end
      end
      R_EX: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      I_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = (bus.opcode == OP_ANDI) ? 2'b11 : 2'b00;
        next_state = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        next_state    = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        retire     = 1'b1;
        next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  // The wait counter restarts on any state change and also on a FETCH
  // timeout, which re-enters FETCH without a state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      retired_q <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || timed_out) tmo_cnt <= '0;
      else if (waiting)                       tmo_cnt <= tmo_cnt + 16'd1;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.illegal_op    = illegal_op;
  assign bus.mem_fault     = mem_fault;
  assign bus.retired       = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl (TIMEOUT_CYCLES=4, CNT_W=8).
// Control word layout used for expectations:
//   {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//    mem_to_reg, reg_dst, reg_write, alu_src_a}_{alu_src_b}_{alu_op}_
//   {pc_source}_{illegal_op, mem_fault}
module tb_mips_multicycle_ctrl;

  localparam logic [17:0] C_IDLE    = 18'b0000000000_00_00_00_00;
  localparam logic [17:0] C_FETCH0  = 18'b0001000000_01_00_00_00;
  localparam logic [17:0] C_FETCH1  = 18'b1001010000_01_00_00_00;
  localparam logic [17:0] C_FETCHF  = 18'b0001000000_01_00_00_01;
  localparam logic [17:0] C_DEC     = 18'b0000000000_11_00_00_00;
  localparam logic [17:0] C_DECILL  = 18'b0000000000_11_00_00_10;
  localparam logic [17:0] C_MADDR   = 18'b0000000001_10_00_00_00;
  localparam logic [17:0] C_MRD     = 18'b0011000000_00_00_00_00;
  localparam logic [17:0] C_MRDF    = 18'b0011000000_00_00_00_01;
  localparam logic [17:0] C_MWB     = 18'b0000001010_00_00_00_00;
  localparam logic [17:0] C_MWR     = 18'b0010100000_00_00_00_00;
  localparam logic [17:0] C_MWRF    = 18'b0010100000_00_00_00_01;
  localparam logic [17:0] C_REX     = 18'b0000000001_00_10_00_00;
  localparam logic [17:0] C_RWB     = 18'b0000000110_00_00_00_00;
  localparam logic [17:0] C_IEXADD  = 18'b0000000001_10_00_00_00;
  localparam logic [17:0] C_IEXAND  = 18'b0000000001_10_11_00_00;
  localparam logic [17:0] C_IWB     = 18'b0000000010_00_00_00_00;
  localparam logic [17:0] C_BR      = 18'b0100000001_00_01_01_00;
  localparam logic [17:0] C_J       = 18'b1000000000_00_00_10_00;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [17:0] c;
    logic [7:0]  r;
  } vec_t;

  typedef struct packed {
    logic [17:0] c;
    logic [7:0]  r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  exp_t exp_q[$];
  logic [17:0] act_c;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(8)) bus ();

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign act_c = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_source, bus.illegal_op, bus.mem_fault};

  function automatic void add(input logic [5:0] op, input logic rdy,
                              input logic [17:0] c, input logic [7:0] r);
    vec_t v;
    v.op = op; v.rdy = rdy; v.c = c; v.r = r;
    vecs.push_back(v);
  endfunction

  // Pops the oldest expectation and compares it against the live outputs.
  task automatic check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    n_vec++;
    if (act_c !== e.c || bus.retired !== e.r || (bus.mem_read && bus.mem_write)) begin
      n_err++;
      $display("FAIL %s: ctrl got %b want %b, retired got %0d want %0d",
               name, act_c, e.c, bus.retired, e.r);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare at negedge.
  task automatic step(input logic [5:0] op, input logic rdy,
                      input logic [17:0] c, input logic [7:0] r, input string name);
    exp_t e;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    e.c = c; e.r = r;
    exp_q.push_back(e);
    @(negedge clk);
    check(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] r;
    exp_t e;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;

    // R-type
    add(OP_R, 0, C_IDLE, 0);
    add(OP_R, 1, C_FETCH1, 0); add(OP_R, 0, C_DEC, 0);
    add(OP_R, 0, C_REX, 0);    add(OP_R, 0, C_RWB, 0);
    // lw with three wait cycles in MEM_RD
    add(OP_LW, 1, C_FETCH1, 1); add(OP_LW, 0, C_DEC, 1); add(OP_LW, 0, C_MADDR, 1);
    add(OP_LW, 0, C_MRD, 1); add(OP_LW, 0, C_MRD, 1); add(OP_LW, 0, C_MRD, 1);
    add(OP_LW, 1, C_MRD, 1); add(OP_LW, 0, C_MWB, 1);
    // beq with one fetch wait
    add(OP_BEQ, 0, C_FETCH0, 2); add(OP_BEQ, 1, C_FETCH1, 2);
    add(OP_BEQ, 0, C_DEC, 2);    add(OP_BEQ, 0, C_BR, 2);
    // andi, addi, j
    add(OP_ANDI, 1, C_FETCH1, 3); add(OP_ANDI, 0, C_DEC, 3);
    add(OP_ANDI, 0, C_IEXAND, 3); add(OP_ANDI, 0, C_IWB, 3);
    add(OP_ADDI, 1, C_FETCH1, 4); add(OP_ADDI, 0, C_DEC, 4);
    add(OP_ADDI, 0, C_IEXADD, 4); add(OP_ADDI, 0, C_IWB, 4);
    add(OP_J, 1, C_FETCH1, 5); add(OP_J, 0, C_DEC, 5); add(OP_J, 0, C_J, 5);
    // illegal opcode, then an R-type to confirm return to FETCH
    add(OP_BAD, 1, C_FETCH1, 6); add(OP_BAD, 0, C_DECILL, 6);
    add(OP_R, 1, C_FETCH1, 6); add(OP_R, 0, C_DEC, 6);
    add(OP_R, 0, C_REX, 6);    add(OP_R, 0, C_RWB, 6);
    // sw timeout, then sw completing on the last allowed cycle
    add(OP_SW, 1, C_FETCH1, 7); add(OP_SW, 0, C_DEC, 7); add(OP_SW, 0, C_MADDR, 7);
    add(OP_SW, 0, C_MWR, 7); add(OP_SW, 0, C_MWR, 7); add(OP_SW, 0, C_MWR, 7);
    add(OP_SW, 0, C_MWRF, 7);
    add(OP_SW, 1, C_FETCH1, 7); add(OP_SW, 0, C_DEC, 7); add(OP_SW, 0, C_MADDR, 7);
    add(OP_SW, 0, C_MWR, 7); add(OP_SW, 0, C_MWR, 7); add(OP_SW, 0, C_MWR, 7);
    add(OP_SW, 1, C_MWR, 7);
    // lw timeout, then fetch timeout, then a normal R-type
    add(OP_LW, 1, C_FETCH1, 8); add(OP_LW, 0, C_DEC, 8); add(OP_LW, 0, C_MADDR, 8);
    add(OP_LW, 0, C_MRD, 8); add(OP_LW, 0, C_MRD, 8); add(OP_LW, 0, C_MRD, 8);
    add(OP_LW, 0, C_MRDF, 8);
    add(OP_R, 0, C_FETCH0, 8); add(OP_R, 0, C_FETCH0, 8); add(OP_R, 0, C_FETCH0, 8);
    add(OP_R, 0, C_FETCHF, 8);
    add(OP_R, 1, C_FETCH1, 8); add(OP_R, 0, C_DEC, 8);
    add(OP_R, 0, C_REX, 8);    add(OP_R, 0, C_RWB, 8);

    @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (vecs[i])
      step(vecs[i].op, vecs[i].rdy, vecs[i].c, vecs[i].r, $sformatf("vec%0d", i));

    // 256 jumps: retired wraps through 255 -> 0 and returns to 9
    r = 8'd9;
    for (int unsigned k = 0; k < 256; k++) begin
      step(OP_J, 1, C_FETCH1, r, "wrap_fetch");
      step(OP_J, 0, C_DEC, r, "wrap_dec");
      step(OP_J, 0, C_J, r, "wrap_jump");
      r = r + 8'd1;
    end

    // Reset asserted mid MEM_WR
    step(OP_SW, 1, C_FETCH1, r, "rst_fetch");
    step(OP_SW, 0, C_DEC, r, "rst_dec");
    step(OP_SW, 0, C_MADDR, r, "rst_maddr");
    step(OP_SW, 0, C_MWR, r, "rst_mwr");
    #2;
    rst = 1'b1;
    #1;
    e.c = C_IDLE; e.r = 8'd0;
    exp_q.push_back(e);
    check("rst_async");
    @(posedge clk);
    #2;
    exp_q.push_back(e);
    check("rst_held");
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(OP_R, 1, C_FETCH1, 0, "post_rst_fetch");
    step(OP_R, 0, C_DEC, 0, "post_rst_dec");
    step(OP_R, 0, C_REX, 0, "post_rst_rex");
    step(OP_R, 0, C_RWB, 0, "post_rst_rwb");
    step(OP_R, 0, C_FETCH0, 1, "post_rst_retired");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
